// File: rtl/alu_op_if.sv
// ---------------------------------------------------------------------------
// alu_op_if
//   Bundles the three channels around the ALU operand driver:
//     cmd_*  : command handshake from decode (valid/ready plus fields)
//     alu_*  : operands/funct out to the combinational ALU, result/flag back
//     rsp_*  : result handshake to the consumer (valid/ready plus payload)
//   master : the driver side (alu_op_driver)
//   slave  : the environment side (decode, ALU, consumer)
// Parameters
//   DATA_W  operand/result width
//   REG_AW  register index width
// ---------------------------------------------------------------------------
interface alu_op_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_funct;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs;
  logic [REG_AW-1:0] cmd_rt;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_funct;
  logic [DATA_W-1:0] alu_out;
  logic              alu_flagz;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_funct, cmd_rd, cmd_rs, cmd_rt, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_funct,
    input  alu_out, alu_flagz,
    output rsp_valid, rsp_data, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_funct, cmd_rd, cmd_rs, cmd_rt, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_funct,
    output alu_out, alu_flagz,
    input  rsp_valid, rsp_data, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_driver.sv
// ---------------------------------------------------------------------------
// alu_op_driver
//   Initiator side of the ALU operand/funct interface. Accepts one command per
//   handshake, reads operands from an internal register file (r0 hard-wired to
//   zero), drives the combinational ALU with registered A/B/funct, captures the
//   result and zero flag, writes the result back to rd and returns it on the
//   response handshake. One command in flight: IDLE -> ISSUE -> CAPTURE -> RESP.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset (clears state, outputs, registers)
//   bus    alu_op_if.master: cmd_* (in, ready out), alu_* (to/from ALU),
//          rsp_* (out, ready in)
//
// Optional feature
//   ALU_DRV_FUNCT_CHECK_EN : when defined, funct >= 9 is flagged illegal; the
//   ALU is still driven, but the result is not written back and the response
//   carries rsp_data=0, rsp_zero=1, rsp_err=1. When undefined, rsp_err is 0
//   and any funct result is written back and returned as-is.
// ---------------------------------------------------------------------------
module alu_op_driver #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_op_if.master    bus
);

  localparam int NREGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [3:0]        funct_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  logic              accept;
  logic              capture_en;
  logic              illegal;
  logic              wr_en;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // r0 is never written, so a plain array read already returns 0 for it.
  assign rs_val = regs[bus.cmd_rs];
  assign rt_val = regs[bus.cmd_rt];

`ifdef ALU_DRV_FUNCT_CHECK_EN
  assign illegal = (funct_q >= 4'd9);
`else
  assign illegal = 1'b0;
`endif

  assign wr_en = capture_en && (rd_q != '0) && !illegal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    capture_en = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_nxt  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand issue: A/B/funct are registered at accept and then held until the
  // next accepted command, so the ALU inputs never toggle between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
      funct_q <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      alu_a_q <= rs_val;
      alu_b_q <= bus.cmd_use_imm ? bus.cmd_imm : rt_val;
      funct_q <= bus.cmd_funct;
      rd_q    <= bus.cmd_rd;
    end
  end

  // Result capture: taken once in CAPTURE and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (capture_en) begin
      rsp_data_q <= illegal ? '0 : bus.alu_out;
      rsp_zero_q <= illegal ? 1'b1 : bus.alu_flagz;
      rsp_err_q  <= illegal;
    end
  end

  // Register file writeback; the write lands before the next command can be
  // accepted, so back-to-back commands see each other's results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_q] <= bus.alu_out;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_funct = funct_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
